// File: rtl/mem_bus_master_if.sv
// Transaction and memory-control signals of the sysbus initiator.
// The shared tri-state sysbus itself stays a plain inout on the top.
interface mem_bus_master_if #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
);
  localparam int ADDR_W = WORD_W - OP_W;

  logic              req;
  logic              rnw;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [WORD_W-1:0] rdata;
  logic              mem_wait;
  logic              load_MAR;
  logic              load_MDR;
  logic              MDR_bus;
  logic              CS;
  logic              R_NW;

  modport master (
    input  req, rnw, addr, wdata, mem_wait,
    output busy, done, err, rdata,
    output load_MAR, load_MDR, MDR_bus, CS, R_NW
  );

  modport slave (
    output req, rnw, addr, wdata, mem_wait,
    input  busy, done, err, rdata,
    input  load_MAR, load_MDR, MDR_bus, CS, R_NW
  );
endinterface

// File: rtl/mem_bus_master.sv
// Sysbus initiator: turns req/ack transactions into the
// MAR/MDR control sequence, with wait states and a timeout.
module mem_bus_master #(
  parameter int WORD_W  = 8,
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              n_reset,
  mem_bus_master_if.master  bus,
  inout  wire  [WORD_W-1:0] sysbus
);
  localparam int ADDR_W = WORD_W - OP_W;
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, ADDR, READ, WDATA, WCOMMIT
  } state_t;

  state_t            state, state_nxt;
  logic              rnw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q, rdata_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic              done_q, done_nxt;
  logic              err_q, err_nxt;
  logic              cap, waiting, ready;
  logic              drive;
  logic [WORD_W-1:0] bus_val;
  logic              load_mar, load_mdr;
  logic              mdr_bus, cs, r_nw;

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state   <= IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt     <= '0;
      rnw_q   <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      rdata_q <= rdata_nxt;
      cnt     <= cnt_nxt;
      if (cap) begin
        rnw_q   <= bus.rnw;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rdata_nxt = rdata_q;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    cap       = 1'b0;
    waiting   = 1'b0;
    ready     = 1'b0;
    drive     = 1'b0;
    bus_val   = '0;
    load_mar  = 1'b0;
    load_mdr  = 1'b0;
    mdr_bus   = 1'b0;
    cs        = 1'b0;
    r_nw      = 1'b1;
    unique case (state)
      IDLE: begin
        if (bus.req) begin
          cap       = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        drive     = 1'b1;
        bus_val   = {{OP_W{1'b0}}, addr_q};
        load_mar  = 1'b1;
        state_nxt = rnw_q ? READ : WDATA;
      end
      READ: begin
        cs      = 1'b1;
        mdr_bus = 1'b1;
        waiting = 1'b1;
        if (!bus.mem_wait) rdata_nxt = sysbus;
      end
      WDATA: begin
        drive     = 1'b1;
        bus_val   = wdata_q;
        load_mdr  = 1'b1;
        cs        = 1'b1;
        r_nw      = 1'b0;
        state_nxt = WCOMMIT;
      end
      WCOMMIT: begin
        drive   = 1'b1;
        bus_val = wdata_q;
        cs      = 1'b1;
        r_nw    = 1'b0;
        waiting = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // Shared stall handling for READ and WCOMMIT
    if (waiting) begin
      ready = !bus.mem_wait;
      if (ready) begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else if (cnt == TMO) begin
        err_nxt   = 1'b1;
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 8'd1;
      end
    end
  end

  assign sysbus       = drive ? bus_val : {WORD_W{1'bz}};
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rdata    = rdata_q;
  assign bus.load_MAR = load_mar;
  assign bus.load_MDR = load_mdr;
  assign bus.MDR_bus  = mdr_bus;
  assign bus.CS       = cs;
  assign bus.R_NW     = r_nw;
endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master: random transactions,
// a RAM responder on sysbus, and a transaction-level model.
module tb_mem_bus_master;
  localparam int WORD_W  = 8;
  localparam int OP_W    = 3;
  localparam int TIMEOUT = 15;

  logic clock = 1'b0;
  logic n_reset = 1'b0;
  tri1 [WORD_W-1:0] sysbus;

  mem_bus_master_if #(.WORD_W(WORD_W), .OP_W(OP_W)) ifc();

  mem_bus_master #(
    .WORD_W(WORD_W), .OP_W(OP_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .n_reset(n_reset),
    .bus(ifc.master),
    .sysbus(sysbus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] wdata;
    logic       is_err;
    logic [7:0] rdata;
    int         due;
  } exp_t;

  exp_t       sb[$];
  int         wq[$];
  logic [7:0] mem_arr [32];
  logic [7:0] ref_mem [32];
  logic [4:0] mar;
  logic [7:0] mdr;
  logic [7:0] last_rd;
  int         wleft = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  int         checks = 0;
  int         passed = 0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endfunction

  // RAM responder
  assign sysbus = ifc.MDR_bus ? mem_arr[mar] : 8'hzz;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (ifc.load_MAR) mar <= sysbus[4:0];
    if (ifc.load_MDR) mdr <= sysbus;
    if (ifc.CS && !ifc.R_NW && !ifc.load_MDR && !ifc.mem_wait)
      mem_arr[mar] <= mdr;
  end

  always @(negedge clock) begin
    if (ifc.load_MAR) begin
      wleft = (wq.size() > 0) ? wq.pop_front() : 0;
      ifc.mem_wait = 1'($urandom % 2);
    end else if (ifc.MDR_bus ||
                 (ifc.CS && !ifc.R_NW && !ifc.load_MDR)) begin
      ifc.mem_wait = (wleft > 0);
      if (wleft > 0) wleft--;
    end else begin
      ifc.mem_wait = 1'($urandom % 2);
    end
  end

  // Monitor: completions and per-phase bus contents
  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      if (ifc.done || ifc.err) begin
        if (sb.size() == 0) begin
          chk("spurious_pulse", 32'({ifc.done, ifc.err}), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done", 32'(ifc.done), 32'(!e.is_err));
          chk("err", 32'(ifc.err), 32'(e.is_err));
          chk("rdata", 32'(ifc.rdata), 32'(e.rdata));
          chk("latency", cyc, e.due);
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        chk("overdue", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (sb.size() > 0) begin
        if (ifc.load_MAR)
          chk("addr_phase", 32'(sysbus), 32'({3'b000, sb[0].addr}));
        if (ifc.load_MDR)
          chk("wdata_phase", 32'({sysbus, ifc.R_NW}),
              32'({sb[0].wdata, 1'b0}));
        if (ifc.CS && !ifc.R_NW && !ifc.load_MDR)
          chk("commit_bus", 32'(sysbus), 32'(sb[0].wdata));
        if (ifc.MDR_bus)
          chk("read_ctl",
              32'({ifc.R_NW, ifc.CS, ifc.load_MAR, ifc.load_MDR}),
              32'(4'b1100));
      end
      if (!ifc.busy)
        chk("idle_outputs",
            32'({sysbus, ifc.CS, ifc.R_NW, ifc.load_MAR,
                 ifc.load_MDR, ifc.MDR_bus}),
            32'({8'hFF, 5'b01000}));
    end
  end

  task automatic issue(input logic r, input logic [4:0] a,
                       input logic [7:0] d, input int w);
    exp_t e;
    int   lat;
    int   n = 0;
    @(negedge clock);
    while (ifc.busy) begin
      ifc.req   = 1'($urandom % 2);
      ifc.rnw   = 1'($urandom % 2);
      ifc.addr  = 5'($urandom);
      ifc.wdata = 8'($urandom);
      @(negedge clock);
      n++;
      if (n > 100) begin
        $display("FAIL issue_wait: busy stuck %0d cycles", n);
        $fatal(1, "busy never dropped");
      end
    end
    ifc.req   = 1'b1;
    ifc.rnw   = r;
    ifc.addr  = a;
    ifc.wdata = d;
    if (w > TIMEOUT) begin
      e.is_err = 1'b1;
      lat = (r ? 2 : 3) + TIMEOUT + 1;
    end else begin
      e.is_err = 1'b0;
      lat = (r ? 3 : 4) + w;
      if (r) last_rd = ref_mem[a];
      else ref_mem[a] = d;
    end
    e.addr  = a;
    e.wdata = d;
    e.rdata = last_rd;
    e.due   = cyc + lat;
    sb.push_back(e);
    wq.push_back(w);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      ifc.req  = 1'b0;
      ifc.addr = 5'($urandom);
    end
  endtask

  initial begin
    int t;
    int wsel [9] = '{0, 0, 0, 1, 2, 4, 15, 16, 40};
    for (int i = 0; i < 32; i++) begin
      mem_arr[i] = 8'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[3] = 8'hAB;
    ref_mem[3] = 8'hAB;
    last_rd = 8'h00;
    ifc.req = 1'b0;
    ifc.rnw = 1'b0;
    ifc.addr = '0;
    ifc.wdata = '0;
    ifc.mem_wait = 1'b0;

    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_pulses", 32'({ifc.done, ifc.err}), 32'd0);
    chk("rst_bus", 32'(sysbus), 32'hFF);
    n_reset = 1'b1;

    // Stall a write in its commit phase, then reset it
    issue(1'b0, 5'd9, 8'h77, 40);
    @(negedge clock);
    ifc.req = 1'b0;
    t = 0;
    while (!(ifc.CS && !ifc.R_NW && !ifc.load_MDR)) begin
      @(negedge clock);
      t++;
      if (t > 50) begin
        $display("FAIL reach_commit: state not reached");
        $fatal(1, "commit phase never reached");
      end
    end
    repeat (3) @(negedge clock);
    n_reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("midrst_busy", 32'(ifc.busy), 32'd0);
    chk("midrst_pulses", 32'({ifc.done, ifc.err}), 32'd0);
    chk("midrst_bus", 32'(sysbus), 32'hFF);
    chk("midrst_ctl",
        32'({ifc.CS, ifc.R_NW, ifc.load_MAR, ifc.load_MDR,
             ifc.MDR_bus}), 32'(5'b01000));
    chk("midrst_rdata", 32'(ifc.rdata), 32'd0);
    n_reset = 1'b1;
    sb.delete();
    wq.delete();
    last_rd = 8'h00;
    mon_en = 1'b1;

    issue(1'b1, 5'd3, 8'h00, 0);
    issue(1'b0, 5'd21, 8'h5C, 0);
    issue(1'b1, 5'd21, 8'h00, 0);
    issue(1'b1, 5'd9, 8'h00, 0);
    issue(1'b1, 5'd3, 8'h00, 4);
    issue(1'b1, 5'd7, 8'h00, 40);
    issue(1'b1, 5'd21, 8'h00, 15);
    issue(1'b1, 5'd3, 8'h00, 16);
    issue(1'b0, 5'd4, 8'hE1, 16);
    issue(1'b1, 5'd4, 8'h00, 0);

    for (int k = 0; k < 300; k++) begin
      if ($urandom % 4 == 0) idle(1 + int'($urandom % 2));
      issue(1'($urandom % 2), 5'($urandom), 8'($urandom),
            wsel[$urandom % 9]);
    end

    t = 0;
    while (sb.size() > 0 && t < 100) begin
      @(negedge clock);
      ifc.req = 1'b0;
      t++;
    end
    if (sb.size() > 0) chk("drain", sb.size(), 0);
    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
